// File: rtl/seq_arithmetic_if.sv
// Operand/result bundle between the capture logic (master) and the arithmetic unit (slave).
interface seq_arithmetic_if #(
    parameter int WIDTH = 4
) ();
    logic                 start;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic [1:0]           operation;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     remainder;
    logic                 overflow;
    logic                 div_by_zero;

    modport master (
        output start, x, y, operation,
        input  busy, done, result, remainder, overflow, div_by_zero
    );

    modport slave (
        input  start, x, y, operation,
        output busy, done, result, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_arithmetic.sv
// Multi-cycle add/sub/shift-add multiply/restoring divide; add/sub/div-by-zero finish in 1 cycle, mul/div in WIDTH+1.
// Starts are ignored while busy (CALC and DONE); results hold until the next done.
module seq_arithmetic #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    seq_arithmetic_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state_q;
    logic [1:0]             op_q;
    logic [WIDTH-1:0]       b_q;
    logic [CW-1:0]          cnt_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic                   busy_q;
    logic                   done_q;
    logic [2*WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]       rem_q;
    logic                   ovf_q;
    logic                   dbz_q;

    logic [WIDTH:0]         add_sum;
    logic [WIDTH-1:0]       sub_diff;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH-1:0]       div_diff;
    logic                   div_ge;
    logic [2*WIDTH-1:0]     div_next;

    // acc_q holds {partial product high, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        add_sum   = {1'b0, bus.x} + {1'b0, bus.y};
        sub_diff  = bus.x - bus.y;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.operation;
                        b_q    <= bus.y;
                        acc_q  <= {{WIDTH{1'b0}}, bus.x};
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        case (bus.operation)
                            2'b00: begin
                                result_q <= {{(WIDTH-1){1'b0}}, add_sum};
                                rem_q    <= '0;
                                ovf_q    <= add_sum[WIDTH];
                                dbz_q    <= 1'b0;
                                done_q   <= 1'b1;
                                state_q  <= DONE;
                            end
                            2'b01: begin
                                result_q <= {{WIDTH{1'b0}}, sub_diff};
                                rem_q    <= '0;
                                ovf_q    <= (bus.x < bus.y);
                                dbz_q    <= 1'b0;
                                done_q   <= 1'b1;
                                state_q  <= DONE;
                            end
                            2'b11: begin
                                if (bus.y == '0) begin
                                    result_q <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                    rem_q    <= bus.x;
                                    ovf_q    <= 1'b0;
                                    dbz_q    <= 1'b1;
                                    done_q   <= 1'b1;
                                    state_q  <= DONE;
                                end else begin
                                    state_q  <= CALC;
                                end
                            end
                            default: state_q <= CALC;
                        endcase
                    end
                end
                CALC: begin
                    acc_q <= op_q[0] ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        if (op_q[0]) begin
                            result_q <= {{WIDTH{1'b0}}, div_next[WIDTH-1:0]};
                            rem_q    <= div_next[2*WIDTH-1:WIDTH];
                        end else begin
                            result_q <= mul_next;
                            rem_q    <= '0;
                        end
                        ovf_q   <= 1'b0;
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.remainder   = rem_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_arithmetic.sv
// Directed bench for seq_arithmetic at WIDTH=4 and WIDTH=8 with hand-computed results.
module tb_seq_arithmetic;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_arithmetic_if #(.WIDTH(4)) i4 ();
    seq_arithmetic_if #(.WIDTH(8)) i8 ();

    seq_arithmetic #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(i4.slave));
    seq_arithmetic #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(i8.slave));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the done-cycle outputs, then steps one cycle so the unit is back in IDLE.
    task automatic chk_out(input string t, input int lat, input int elat,
                           input logic [15:0] r, input logic [15:0] er,
                           input logic [7:0] rm, input logic [7:0] erm,
                           input logic ov, input logic eov, input logic dz, input logic edz);
        check({t, "_lat"}, lat, elat);
        check({t, "_result"}, {16'h0, r}, {16'h0, er});
        check({t, "_rem"}, {24'h0, rm}, {24'h0, erm});
        check({t, "_ovf"}, {31'h0, ov}, {31'h0, eov});
        check({t, "_dbz"}, {31'h0, dz}, {31'h0, edz});
        @(negedge clk);
    endtask

    // Called at a negedge; returns cycles to done (accepting edge = cycle 0) and busy cycles seen.
    task automatic run4(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input bit poke, output int lat, output int bcnt);
        i4.start = 1'b1; i4.x = a; i4.y = b; i4.operation = op;
        @(negedge clk);
        i4.start = poke; i4.x = ~a; i4.y = ~b; i4.operation = ~op;
        lat = 1; bcnt = 0;
        while (i4.done !== 1'b1 && lat < 40) begin
            if (i4.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (i4.busy === 1'b1) bcnt++;
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt);
        i8.start = 1'b1; i8.x = a; i8.y = b; i8.operation = op;
        @(negedge clk);
        i8.start = 1'b0; i8.x = ~a; i8.y = ~b; i8.operation = ~op;
        lat = 1; bcnt = 0;
        while (i8.done !== 1'b1 && lat < 40) begin
            if (i8.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (i8.busy === 1'b1) bcnt++;
    endtask

    initial begin
        int lat;
        int bc;
        int dones;

        reset = 1'b1;
        i4.start = 1'b0; i4.x = '0; i4.y = '0; i4.operation = '0;
        i8.start = 1'b0; i8.x = '0; i8.y = '0; i8.operation = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, i4.busy}, 32'h0);
        check("rst_done", {31'h0, i4.done}, 32'h0);
        check("rst_result", {24'h0, i4.result}, 32'h0);
        check("rst_rem", {28'h0, i4.remainder}, 32'h0);
        check("rst_ovf", {31'h0, i4.overflow}, 32'h0);
        check("rst_dbz", {31'h0, i4.div_by_zero}, 32'h0);
        check("rst8_result", {16'h0, i8.result}, 32'h0);
        reset = 1'b0;

        run4(2'b00, 4'd9, 4'd8, 1'b0, lat, bc);
        check("add98_busy", bc, 1);
        chk_out("add98", lat, 1, {8'h0, i4.result}, 16'h0011, {4'h0, i4.remainder}, 8'h0,
                i4.overflow, 1'b1, i4.div_by_zero, 1'b0);
        check("add98_idle_busy", {31'h0, i4.busy}, 32'h0);
        check("add98_hold", {24'h0, i4.result}, 32'h11);

        run4(2'b00, 4'd3, 4'd4, 1'b0, lat, bc);
        chk_out("add34", lat, 1, {8'h0, i4.result}, 16'h0007, {4'h0, i4.remainder}, 8'h0,
                i4.overflow, 1'b0, i4.div_by_zero, 1'b0);

        run4(2'b01, 4'd3, 4'd5, 1'b0, lat, bc);
        chk_out("sub35", lat, 1, {8'h0, i4.result}, 16'h000E, {4'h0, i4.remainder}, 8'h0,
                i4.overflow, 1'b1, i4.div_by_zero, 1'b0);

        run4(2'b01, 4'd5, 4'd3, 1'b0, lat, bc);
        chk_out("sub53", lat, 1, {8'h0, i4.result}, 16'h0002, {4'h0, i4.remainder}, 8'h0,
                i4.overflow, 1'b0, i4.div_by_zero, 1'b0);

        // start held high through CALC and the DONE cycle must be ignored
        run4(2'b10, 4'd15, 4'd15, 1'b1, lat, bc);
        check("mul_busy", bc, 5);
        check("mul_hold_mid", {24'h0, i4.result}, 32'hE1);
        chk_out("mul1515", lat, 5, {8'h0, i4.result}, 16'h00E1, {4'h0, i4.remainder}, 8'h0,
                i4.overflow, 1'b0, i4.div_by_zero, 1'b0);
        i4.start = 1'b0;
        check("mul_after_done", {31'h0, i4.done}, 32'h0);
        check("mul_after_busy", {31'h0, i4.busy}, 32'h0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (i4.done === 1'b1) dones++;
        end
        check("mul_no_extra_done", dones, 0);
        check("mul_result_held", {24'h0, i4.result}, 32'hE1);

        run4(2'b11, 4'd13, 4'd4, 1'b0, lat, bc);
        chk_out("div13_4", lat, 5, {8'h0, i4.result}, 16'h0003, {4'h0, i4.remainder}, 8'h1,
                i4.overflow, 1'b0, i4.div_by_zero, 1'b0);

        run4(2'b11, 4'd7, 4'd0, 1'b0, lat, bc);
        check("div0_busy", bc, 1);
        chk_out("div7_0", lat, 1, {8'h0, i4.result}, 16'h000F, {4'h0, i4.remainder}, 8'h7,
                i4.overflow, 1'b0, i4.div_by_zero, 1'b1);

        // reset in cycle 2 of a multiply: outputs clear at once and the run is dropped
        i4.start = 1'b1; i4.x = 4'd15; i4.y = 4'd15; i4.operation = 2'b10;
        @(negedge clk);
        i4.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'h0, i4.busy}, 32'h0);
        check("midrst_done", {31'h0, i4.done}, 32'h0);
        check("midrst_result", {24'h0, i4.result}, 32'h0);
        check("midrst_rem", {28'h0, i4.remainder}, 32'h0);
        check("midrst_dbz", {31'h0, i4.div_by_zero}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (i4.done === 1'b1) dones++;
        end
        check("midrst_no_done", dones, 0);

        run4(2'b00, 4'd1, 4'd1, 1'b0, lat, bc);
        chk_out("add11", lat, 1, {8'h0, i4.result}, 16'h0002, {4'h0, i4.remainder}, 8'h0,
                i4.overflow, 1'b0, i4.div_by_zero, 1'b0);

        run8(2'b10, 8'd255, 8'd255, lat, bc);
        check("mul8_busy", bc, 9);
        chk_out("mul8", lat, 9, i8.result, 16'hFE01, i8.remainder, 8'h0,
                i8.overflow, 1'b0, i8.div_by_zero, 1'b0);

        run8(2'b11, 8'd200, 8'd7, lat, bc);
        chk_out("div8", lat, 9, i8.result, 16'h001C, i8.remainder, 8'h4,
                i8.overflow, 1'b0, i8.div_by_zero, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
